// File: rtl/uart_rx_deframer_if.sv
// Bundles the serial line input and the received-byte outputs of the UART
// receive front-end. The slave side is the deframer; the master side is
// whoever drives the serial line and consumes the bytes.
interface uart_rx_deframer_if;
    logic       rx_i;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx_i,
        input  rx_data,
        input  new_rx_data,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_i,
        output rx_data,
        output new_rx_data,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receive front-end: synchronises the serial line, oversamples
// each bit, takes a 3-sample majority vote around mid-bit and deframes the
// character. Clean bytes come out with a one-cycle strobe; a low stop bit
// gives a single frame_err pulse and the receiver then waits for the line
// to return high before hunting for the next start bit.
module uart_rx_deframer #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_deframer_if.slave bus
);

    localparam int H           = OVERSAMPLE / 2;
    localparam int SMP_W       = $clog2(OVERSAMPLE);
    localparam int DIV_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SYNC_STAGES = 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_PRE  = SMP_W'(H - 1);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(H);
    localparam logic [SMP_W-1:0] SMP_POST = SMP_W'(H + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    // ------------------------------------------------------------------
    // Two-stage synchroniser; both stages come up high so that leaving
    // reset never looks like the leading edge of a start bit.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rx_s;

    // Shift the raw line into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.rx_i};
    end

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            // One synchroniser stage, reset to the idle (high) line level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q[gi] <= 1'b1;
                end else begin
                    sync_q[gi] <= sync_d[gi];
                end
            end
        end
    endgenerate

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic [2:0]       state_q,       state_d;
    logic [DIV_W-1:0] div_cnt_q,     div_cnt_d;
    logic [SMP_W-1:0] smp_cnt_q,     smp_cnt_d;
    logic [2:0]       bit_idx_q,     bit_idx_d;
    logic [1:0]       samp_q,        samp_d;
    logic [7:0]       shift_q,       shift_d;
    logic [7:0]       rx_data_q,     rx_data_d;
    logic             new_rx_data_q, new_rx_data_d;
    logic             frame_err_q,   frame_err_d;

    logic tick;
    logic maj;
    logic counting;

    // Majority of the two stored samples and the live third sample; only
    // consumed on the tick that captures the third sample.
    always_comb begin
        maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    end

    // Tick divider: runs only while a frame is being timed.
    always_comb begin
        counting  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
        tick      = 1'b0;
        div_cnt_d = '0;
        if (counting) begin
            if (div_cnt_q == DIV_LAST) begin
                tick      = 1'b1;
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // Frame sequencing, mid-bit sampling and output pulse generation.
    always_comb begin
        state_d       = state_q;
        smp_cnt_d     = smp_cnt_q;
        bit_idx_d     = bit_idx_q;
        samp_d        = samp_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        new_rx_data_d = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                smp_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START, S_DATA, S_STOP: begin
                if (tick) begin
                    if (smp_cnt_q == SMP_LAST) begin
                        smp_cnt_d = '0;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end

                    if (smp_cnt_q == SMP_PRE) begin
                        samp_d[0] = rx_s;
                    end
                    if (smp_cnt_q == SMP_MID) begin
                        samp_d[1] = rx_s;
                    end

                    if (smp_cnt_q == SMP_POST) begin
                        if (state_q == S_START) begin
                            // A start bit that is high at mid-bit was noise.
                            if (maj) begin
                                state_d   = S_IDLE;
                                smp_cnt_d = '0;
                            end
                        end else if (state_q == S_DATA) begin
                            shift_d = {maj, shift_q[7:1]};
                        end else begin
                            // Stop bit decided at mid-bit so the next start
                            // edge is never missed on back-to-back frames.
                            smp_cnt_d = '0;
                            bit_idx_d = '0;
                            if (maj) begin
                                rx_data_d     = shift_q;
                                new_rx_data_d = 1'b1;
                                state_d       = S_IDLE;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = S_BREAK;
                            end
                        end
                    end

                    if (smp_cnt_q == SMP_LAST) begin
                        if (state_q == S_START) begin
                            state_d = S_DATA;
                        end else if (state_q == S_DATA) begin
                            if (bit_idx_q == 3'd7) begin
                                state_d = S_STOP;
                            end else begin
                                bit_idx_d = bit_idx_q + 1'b1;
                            end
                        end
                    end
                end
            end

            S_BREAK: begin
                // Hold off until the line is released so a stuck-low line
                // reports one framing error rather than one per character.
                smp_cnt_d = '0;
                bit_idx_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                smp_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // Register all receiver state and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            div_cnt_q     <= '0;
            smp_cnt_q     <= '0;
            bit_idx_q     <= '0;
            samp_q        <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            new_rx_data_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            smp_cnt_q     <= smp_cnt_d;
            bit_idx_q     <= bit_idx_d;
            samp_q        <= samp_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            new_rx_data_q <= new_rx_data_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.new_rx_data = new_rx_data_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: directed scenarios plus random frames. The
// stimulus side records every frame it sends as an expected event; the
// checker pops events on each strobe/error pulse and checks byte, kind and
// latency, and checks rx_data against the last good byte every cycle.
module tb_uart_rx_deframer;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int OS       = 16;
    localparam int BIT_CLK  = CLK_FREQ / BAUD;
    localparam int LAT_MIN  = (BIT_CLK * 19) / 2;
    localparam int LAT_MAX  = LAT_MIN + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_deframer_if u_if ();

    uart_rx_deframer #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         ef;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_last = 8'h00;
    int         tests      = 0;
    int         fails      = 0;
    int         cyc        = 0;
    int         strobe_cnt = 0;
    int         err_cnt    = 0;
    bit         prev_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Checker: runs just after every rising edge while not in reset.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_pulse = 1'b0;
                continue;
            end
            check("pulse_exclusive", 32'(u_if.new_rx_data & u_if.frame_err), 32'd0);
            if (u_if.new_rx_data || u_if.frame_err) begin
                check("pulse_not_consecutive", 32'(prev_pulse), 32'd0);
                if (u_if.new_rx_data) strobe_cnt++;
                if (u_if.frame_err) err_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got strobe=%0b err=%0b data=0x%02h, expected no pulse",
                             u_if.new_rx_data, u_if.frame_err, u_if.rx_data);
                end else begin
                    ev_t e;
                    int  lat;
                    e   = exp_q.pop_front();
                    lat = cyc - e.ef;
                    check("pulse_kind_is_err", 32'(u_if.frame_err), 32'(e.is_err));
                    tests++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        fails++;
                        $display("FAIL latency: got %0d clk, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                    end
                    if (!e.is_err) model_last = e.data;
                    $display("[TB] %s byte=0x%02h rx_data=0x%02h latency=%0d",
                             u_if.new_rx_data ? "strobe" : "frame_err", e.data, u_if.rx_data, lat);
                end
            end
            prev_pulse = u_if.new_rx_data | u_if.frame_err;
            check("rx_data_model", 32'(u_if.rx_data), 32'(model_last));
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One clock-wide line slot, driven on the falling edge.
    task automatic drive_slot(input logic v);
        @(negedge clk);
        u_if.rx_i = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_slot(1'b1);
    endtask

    // Send one 8N1 frame; optionally force the stop bit low, and optionally
    // flip the middle majority sample of each data bit for one clock.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
        logic [9:0] bits;
        ev_t        e;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < BIT_CLK; k++) begin
                if (glitch && i >= 1 && i <= 8 && k == OS / 2 + 1)
                    drive_slot(~bits[i]);
                else
                    drive_slot(bits[i]);
                if (i == 0 && k == 0) begin
                    e.is_err = ~stop;
                    e.data   = d;
                    e.ef     = cyc + 1;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_last = 8'h00;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int s0, e0;
        int rise_c, fall_c, t;
        u_if.rx_i = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rx_data", 32'(u_if.rx_data), 32'h00);
        check("reset_strobe", 32'(u_if.new_rx_data), 32'd0);
        check("reset_frame_err", 32'(u_if.frame_err), 32'd0);
        check("reset_busy", 32'(u_if.busy), 32'd0);
        idle(32);

        // 1: two isolated frames
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        idle(20);
        check("t1_rx_data_55", 32'(u_if.rx_data), 32'h55);
        send_frame(8'hA3, 1'b1, 1'b0);
        idle(40);
        check("t1_rx_data_a3", 32'(u_if.rx_data), 32'hA3);
        check("t1_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("t1_errors", 32'(err_cnt - e0), 32'd0);

        // 2: back-to-back frames, no idle between
        s0 = strobe_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(40);
        check("t2_strobes", 32'(strobe_cnt - s0), 32'd3);
        check("t2_rx_data_7e", 32'(u_if.rx_data), 32'h7E);

        // 3: 3-clk glitch start bit
        s0 = strobe_cnt; e0 = err_cnt;
        rise_c = -1; fall_c = -1;
        for (int i = 0; i < 40; i++) begin
            drive_slot(i < 3 ? 1'b0 : 1'b1);
            if (u_if.busy && rise_c < 0) rise_c = i;
            if (!u_if.busy && rise_c >= 0 && fall_c < 0) fall_c = i;
        end
        check("t3_busy_rose", 32'(rise_c >= 0), 32'd1);
        check("t3_busy_fell_in_12", 32'(fall_c >= 0 && (fall_c - rise_c) <= 12), 32'd1);
        check("t3_strobes", 32'(strobe_cnt - s0), 32'd0);
        check("t3_errors", 32'(err_cnt - e0), 32'd0);
        $display("[TB] glitch start: busy high for %0d clk", fall_c - rise_c);

        // 4: framing error, long break, recovery
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 40 * BIT_CLK; i++) drive_slot(1'b0);
        check("t4_busy_in_break", 32'(u_if.busy), 32'd1);
        check("t4_rx_data_kept", 32'(u_if.rx_data), 32'h7E);
        idle(32);
        check("t4_idle_after_break", 32'(u_if.busy), 32'd0);
        check("t4_one_error", 32'(err_cnt - e0), 32'd1);
        check("t4_no_strobe_3c", 32'(strobe_cnt - s0), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(40);
        check("t4_rx_data_81", 32'(u_if.rx_data), 32'h81);
        check("t4_error_total", 32'(err_cnt - e0), 32'd1);

        // 5: glitch on the middle sample of every data bit
        send_frame(8'hC5, 1'b1, 1'b1);
        idle(40);
        check("t5_rx_data_c5", 32'(u_if.rx_data), 32'hC5);

        // 6: reset during bit 4, then a clean frame
        s0 = strobe_cnt;
        for (int i = 0; i < 5 * BIT_CLK + 8; i++) begin
            t = 8'h0F >> ((i / BIT_CLK) - 1);
            drive_slot((i < BIT_CLK) ? 1'b0 : 1'(t));
        end
        check("t6_busy_mid_frame", 32'(u_if.busy), 32'd1);
        do_reset();
        u_if.rx_i = 1'b1;
        @(negedge clk);
        check("t6_rst_rx_data", 32'(u_if.rx_data), 32'h00);
        check("t6_rst_busy", 32'(u_if.busy), 32'd0);
        check("t6_rst_strobe", 32'(u_if.new_rx_data), 32'd0);
        check("t6_rst_frame_err", 32'(u_if.frame_err), 32'd0);
        idle(32);
        check("t6_no_strobe_aborted", 32'(strobe_cnt - s0), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(40);
        check("t6_rx_data_5a", 32'(u_if.rx_data), 32'h5A);

        // Random frames: random bytes, occasional bad stop bits and glitches.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic       stop;
            logic       gl;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            gl   = 1'($urandom_range(0, 1));
            send_frame(d, stop, gl);
            idle(stop ? $urandom_range(0, 20) : $urandom_range(20, 60));
        end
        idle(BIT_CLK * 4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
